// File: rtl/alu.sv
// Fixed-point neuron arithmetic unit: each enabled cycle it adds a rounded dot
// product to a saturating accumulator. The bias is added once per computation.
module alu #(
    parameter int unsigned SIZE      = 16,
    parameter int unsigned PRECISION = 11,
    parameter int unsigned INPUT_SZ  = 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [INPUT_SZ-1:0][SIZE-1:0]      weights,
    input  logic [INPUT_SZ-1:0][SIZE-1:0]      inputs,
    input  logic [SIZE-1:0]                    bias,
    input  logic                               enable,
    input  logic                               clear,
    output logic [SIZE-1:0]                    value
);

    // Guard bits keep the sum of INPUT_SZ full-precision products from wrapping.
    localparam int unsigned GuardW = $clog2(INPUT_SZ) + 1;
    localparam int unsigned ProdW  = 2 * SIZE;
    localparam int unsigned SumW   = ProdW + GuardW;
    // Two extra bits absorb the accumulator and bias additions.
    localparam int unsigned TotW   = SumW + 2;

    logic [SIZE-1:0]              value_q, value_d;
    logic                         bias_pending_q, bias_pending_d;

    logic signed [ProdW-1:0]      prod [INPUT_SZ];
    logic signed [SumW-1:0]       sum;
    logic signed [SumW-1:0]       round_half;
    logic signed [SumW-1:0]       rounded;
    logic signed [SumW-1:0]       dot;
    logic signed [TotW-1:0]       total;
    logic signed [TotW-1:0]       acc_ext;
    logic signed [TotW-1:0]       bias_ext;
    logic signed [TotW-1:0]       sat_max;
    logic signed [TotW-1:0]       sat_min;
    logic [SIZE-1:0]              sat_result;

    // Full-precision products and their guarded sum.
    always_comb begin
        sum = '0;
        for (int i = 0; i < INPUT_SZ; i++) begin
            prod[i] = $signed(weights[i]) * $signed(inputs[i]);
            sum     = sum + {{GuardW{prod[i][ProdW-1]}}, prod[i]};
        end
    end

    // Round half up once on the sum, then drop the fractional bits.
    always_comb begin
        round_half                = '0;
        round_half[PRECISION-1]   = 1'b1;
        rounded                   = sum + round_half;
        dot                       = rounded >>> PRECISION;
    end

    // Wide total and saturation to the SIZE-bit signed range.
    always_comb begin
        acc_ext  = {{(TotW-SIZE){value_q[SIZE-1]}}, value_q};
        bias_ext = '0;
        if (bias_pending_q) begin
            bias_ext = {{(TotW-SIZE){bias[SIZE-1]}}, bias};
        end
        total   = {{2{dot[SumW-1]}}, dot} + acc_ext + bias_ext;
        sat_max = {{(TotW-SIZE+1){1'b0}}, {(SIZE-1){1'b1}}};
        sat_min = ~sat_max;
        if (total > sat_max) begin
            sat_result = sat_max[SIZE-1:0];
        end else if (total < sat_min) begin
            sat_result = sat_min[SIZE-1:0];
        end else begin
            sat_result = total[SIZE-1:0];
        end
    end

    // Next state: clear wins over enable; otherwise hold.
    always_comb begin
        value_d        = value_q;
        bias_pending_d = bias_pending_q;
        if (clear) begin
            value_d        = '0;
            bias_pending_d = 1'b1;
        end else if (enable) begin
            value_d        = sat_result;
            bias_pending_d = 1'b0;
        end
    end

    // Accumulator and bias flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q        <= '0;
            bias_pending_q <= 1'b1;
        end else begin
            value_q        <= value_d;
            bias_pending_q <= bias_pending_d;
        end
    end

    assign value = value_q;

endmodule

// File: tb/tb_alu.sv
// Directed, table-driven bench for the alu neuron accumulator.
module tb_alu;

    logic               clk;
    logic               rst_n;
    logic [1:0][15:0]   weights;
    logic [1:0][15:0]   inputs;
    logic [15:0]        bias;
    logic               enable;
    logic               clear;
    logic [15:0]        value;

    int tests;
    int fails;

    alu #(
        .SIZE      (16),
        .PRECISION (11),
        .INPUT_SZ  (2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .weights (weights),
        .inputs  (inputs),
        .bias    (bias),
        .enable  (enable),
        .clear   (clear),
        .value   (value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          pre_clear;
        logic [15:0] w1, w0, i1, i0, b;
        bit          en, clr;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [15:0] exp);
        tests++;
        if (value !== exp) begin
            fails++;
            $display("FAIL %s: value=%h expected=%h", name, value, exp);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear  = 1'b1;
        enable = 1'b0;
        step();
        clear  = 1'b0;
        check("after_clear", 16'h0000);
    endtask

    task automatic drive(input vec_t v);
        weights = {v.w1, v.w0};
        inputs  = {v.i1, v.i0};
        bias    = v.b;
        enable  = v.en;
        clear   = v.clr;
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        weights = '0;
        inputs  = '0;
        bias    = '0;
        enable  = 1'b0;
        clear   = 1'b0;
        rst_n   = 1'b0;

        vecs[0]  = '{"basic_6p5",  1, 16'h0800, 16'h0400, 16'h1800, 16'h2000, 16'h0C00, 1, 0, 16'h3400};
        vecs[1]  = '{"bias_first", 1, 16'h0800, 16'h0800, 16'h0800, 16'h0800, 16'h0800, 1, 0, 16'h1800};
        vecs[2]  = '{"bias_once",  0, 16'h0800, 16'h0800, 16'h0800, 16'h0800, 16'h0800, 1, 0, 16'h2800};
        vecs[3]  = '{"negative",   1, 16'hF800, 16'h0000, 16'h1800, 16'h0000, 16'h0400, 1, 0, 16'hEC00};
        vecs[4]  = '{"sat_pos",    1, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1, 0, 16'h7FFF};
        vecs[5]  = '{"sat_neg",    1, 16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF, 16'h8000, 1, 0, 16'h8000};
        vecs[6]  = '{"round_up",   1, 16'h0001, 16'h0000, 16'h0400, 16'h0000, 16'h0000, 1, 0, 16'h0001};
        vecs[7]  = '{"hold",       0, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 0, 0, 16'h0001};
        vecs[8]  = '{"round_down", 1, 16'h0001, 16'h0000, 16'h03FF, 16'h0000, 16'h0000, 1, 0, 16'h0000};
        vecs[9]  = '{"pre_prio",   1, 16'h0800, 16'h0400, 16'h1800, 16'h2000, 16'h0C00, 1, 0, 16'h3400};
        vecs[10] = '{"clr_and_en", 0, 16'h0800, 16'h0400, 16'h1800, 16'h2000, 16'h0C00, 1, 1, 16'h0000};

        #2;
        check("reset_value", 16'h0000);
        #10;
        rst_n = 1'b1;
        step();

        for (int k = 0; k < 11; k++) begin
            if (vecs[k].pre_clear) do_clear();
            drive(vecs[k]);
            step();
            check(vecs[k].name, vecs[k].exp);
        end

        // Bias must be pending again after clear+enable.
        drive(vecs[0]);
        step();
        check("bias_after_clr_en", 16'h3400);

        // Asynchronous reset mid-computation, away from any clock edge.
        enable = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 16'h0000);
        #3;
        rst_n = 1'b1;
        drive(vecs[0]);
        step();
        check("after_reset", 16'h3400);

        enable = 1'b0;
        step();
        check("hold_after_reset", 16'h3400);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
